enemy_wave_controller: RTL and testbench
========================================

ENEMY_WAVE_CONTROLLER -- requirements
Module: enemy_wave_controller

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000: clk cycles per game tick (>=2).
REQ-002 SHALL have parameter SPAWN_GAP, default 8: game ticks between spawn attempts (>=1).
REQ-003 SHALL have parameter WAVE_SIZE, default 8: enemies spawned per wave (1..255).
REQ-004 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-005 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port start  input  1  one-cycle pulse that begins a wave; honoured only in IDLE or DONE.
REQ-007 SHALL have port enemyDead  input  4  per-slot dead flag from the four enemy units; bit i = slot i.
REQ-008 SHALL have port enemyPos  input  36  slot i position at bits [9i+8:9i], unsigned.
REQ-009 SHALL have port enemyDmg  input  32  slot i damageOut at bits [8i+7:8i].
REQ-010 SHALL have port playerDmgIn  input  8  damage player units deal to the frontmost enemy.
REQ-011 SHALL have port canSpawn  output  4  one-hot spawn grant, bit i to slot i.
REQ-012 SHALL have port moveSCEN  output  1  game-tick strobe to all enemies.
REQ-013 SHALL have port damageSCEN  output  1  damage-apply strobe to all enemies.
REQ-014 SHALL have port damageToEnemy  output  32  slot i damageIn at bits [8i+7:8i].
REQ-015 SHALL have port enemyFront  output  9  largest position among alive slots (unitFront for player side).
REQ-016 SHALL have port damageToPlayer  output  10  sum of enemyDmg over alive slots.
REQ-017 SHALL have port waveDone  output  1  level, high in DONE.
REQ-018 SHALL have port busy  output  1  high in SPAWN or CLEAR.

Function
REQ-019 SHALL implement states IDLE, SPAWN, CLEAR, DONE; start in IDLE/DONE -> SPAWN, clearing spawned count, pending bits and tick counter, loading gap counter with SPAWN_GAP-1.
REQ-020 SHALL run a tick counter 0..TICK_DIV-1 only in SPAWN and CLEAR, wrapping to 0; the cycle after the counter reaches TICK_DIV-1, moveSCEN and damageSCEN SHALL both be high for exactly one cycle.
REQ-021 SHALL, on each tick in SPAWN, increment the gap counter if below SPAWN_GAP-1, else make a spawn attempt.
REQ-022 Spawn attempt SHALL grant the lowest-index slot with enemyDead=1 and pending=0: canSpawn bit high in the same cycle as moveSCEN, pending bit set, spawned count +1, gap counter reset to 0.
REQ-023 If no slot is free, gap counter SHALL hold at SPAWN_GAP-1 and retry on each following tick.
REQ-024 A slot's pending bit SHALL clear on the first cycle its enemyDead is observed 0; pending slots count as not free and not alive.
REQ-025 When spawned count reaches WAVE_SIZE, SHALL move SPAWN -> CLEAR on the next cycle; no further canSpawn.
REQ-026 In CLEAR, SHALL move to DONE when enemyDead=4'b1111 and all pending bits are 0.
REQ-027 Alive = enemyDead 0 and pending 0; enemyFront and front-slot index SHALL be registered (1-cycle latency); enemyFront = 0 with no slot alive; ties go to the lowest index.
REQ-028 damageToEnemy SHALL route playerDmgIn to the registered front slot only if that slot is alive; all other fields 0; all 0 with no slot alive.
REQ-029 damageToPlayer SHALL be a registered 10-bit sum (max 1020, no overflow) of enemyDmg over alive slots, 1-cycle latency.
REQ-030 start while in SPAWN or CLEAR SHALL be ignored.

Reset
REQ-031 reset SHALL force IDLE immediately, including mid-wave, and clear all counters and pending bits.
REQ-032 Reset values: canSpawn=0, moveSCEN=0, damageSCEN=0, damageToEnemy=0, enemyFront=0, damageToPlayer=0, waveDone=0, busy=0.

Verification (TICK_DIV=4, SPAWN_GAP=2, WAVE_SIZE=3, behavioural enemy models)
REQ-033 Tick: start, enemyDead=4'hF -> moveSCEN/damageSCEN single-cycle pulses every 4 cycles; canSpawn=4'b0001 on the first pulse.
REQ-034 Spawn spacing: slot 0 alive -> next grant canSpawn=4'b0010 two ticks later; third grant 4'b0100; then CLEAR, busy=1, no more grants.
REQ-035 Full slots: all four alive with WAVE_SIZE=6 -> no grant; when slot 2 dies, canSpawn=4'b0100 on the next tick.
REQ-036 Front/damage: positions 10,30,30 alive in slots 0,1,2, playerDmgIn=8'd5 -> enemyFront=30, damageToEnemy slot 1 field=5, others 0; enemyDmg 32,32,0 -> damageToPlayer=64.
REQ-037 Completion: all enemies die in CLEAR -> waveDone=1, busy=0; start -> SPAWN, waveDone=0.
REQ-038 Reset mid-SPAWN with one grant pending -> all outputs 0 asynchronously; state IDLE; no canSpawn until next start.

Source files
------------

// File: rtl/enemy_wave_controller.sv
// Enemy wave controller: paces spawns on a divided game tick, tracks the frontmost
// alive enemy, and aggregates damage between the player side and four enemy slots.
module enemy_wave_controller #(
    parameter int TICK_DIV  = 50000,
    parameter int SPAWN_GAP = 8,
    parameter int WAVE_SIZE = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  enemyDead,
    input  logic [35:0] enemyPos,
    input  logic [31:0] enemyDmg,
    input  logic [7:0]  playerDmgIn,
    output logic [3:0]  canSpawn,
    output logic        moveSCEN,
    output logic        damageSCEN,
    output logic [31:0] damageToEnemy,
    output logic [8:0]  enemyFront,
    output logic [9:0]  damageToPlayer,
    output logic        waveDone,
    output logic        busy
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int GW = (SPAWN_GAP > 1) ? $clog2(SPAWN_GAP) : 1;
    localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
    localparam logic [GW-1:0] GAP_MAX  = GW'(SPAWN_GAP - 1);
    localparam logic [7:0]    WAVE_N   = 8'(WAVE_SIZE);

    typedef enum logic [1:0] {IDLE, SPAWN, CLEAR, DONE} state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   tickCnt_q, tickCnt_d;
    logic [GW-1:0]   gapCnt_q, gapCnt_d;
    logic [7:0]      spawned_q, spawned_d;
    logic [3:0]      pending_q, pending_d;
    logic [3:0]      canSpawn_q, canSpawn_d;
    logic            tickPulse_q, tickPulse_d;
    logic [8:0]      frontPos_q, frontPos_d;
    logic [1:0]      frontIdx_q, frontIdx_d;
    logic            frontValid_q, frontValid_d;
    logic [9:0]      dmgSum_q, dmgSum_d;

    logic            active;
    logic            tickEnd;
    logic [3:0]      alive;
    logic [3:0]      freeSlots;
    logic [3:0]      grant;

    // A freshly granted slot stays pending until its unit reports alive, so it is
    // neither re-granted nor targeted while the spawn propagates.
    assign active    = (state_q == SPAWN) || (state_q == CLEAR);
    assign tickEnd   = active && (tickCnt_q == TICK_MAX);
    assign alive     = ~enemyDead & ~pending_q;
    assign freeSlots = enemyDead & ~pending_q;
    assign grant     = freeSlots & (~freeSlots + 4'd1);

    always_comb begin
        state_d     = state_q;
        tickCnt_d   = tickCnt_q;
        gapCnt_d    = gapCnt_q;
        spawned_d   = spawned_q;
        pending_d   = pending_q & enemyDead;
        canSpawn_d  = '0;
        tickPulse_d = tickEnd;
        if (active) begin
            tickCnt_d = tickEnd ? '0 : tickCnt_q + TW'(1);
        end
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = SPAWN;
                    tickCnt_d = '0;
                    gapCnt_d  = GAP_MAX;
                    spawned_d = '0;
                    pending_d = '0;
                end
            end
            SPAWN: begin
                if (spawned_q >= WAVE_N) begin
                    state_d = CLEAR;
                end else if (tickEnd) begin
                    if (gapCnt_q < GAP_MAX) begin
                        gapCnt_d = gapCnt_q + GW'(1);
                    end else if (freeSlots != 4'd0) begin
                        canSpawn_d = grant;
                        pending_d  = pending_d | grant;
                        spawned_d  = spawned_q + 8'd1;
                        gapCnt_d   = '0;
                    end
                end
            end
            CLEAR: begin
                if ((enemyDead == 4'hF) && (pending_q == 4'd0)) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Strict greater-than keeps ties on the lowest index.
    always_comb begin
        frontPos_d   = '0;
        frontIdx_d   = '0;
        frontValid_d = 1'b0;
        dmgSum_d     = '0;
        for (int i = 0; i < 4; i++) begin
            if (alive[i]) begin
                dmgSum_d = dmgSum_d + 10'(enemyDmg[8*i +: 8]);
                if (!frontValid_d || (enemyPos[9*i +: 9] > frontPos_d)) begin
                    frontPos_d   = enemyPos[9*i +: 9];
                    frontIdx_d   = 2'(i);
                    frontValid_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            tickCnt_q    <= '0;
            gapCnt_q     <= '0;
            spawned_q    <= '0;
            pending_q    <= '0;
            canSpawn_q   <= '0;
            tickPulse_q  <= 1'b0;
            frontPos_q   <= '0;
            frontIdx_q   <= '0;
            frontValid_q <= 1'b0;
            dmgSum_q     <= '0;
        end else begin
            state_q      <= state_d;
            tickCnt_q    <= tickCnt_d;
            gapCnt_q     <= gapCnt_d;
            spawned_q    <= spawned_d;
            pending_q    <= pending_d;
            canSpawn_q   <= canSpawn_d;
            tickPulse_q  <= tickPulse_d;
            frontPos_q   <= frontPos_d;
            frontIdx_q   <= frontIdx_d;
            frontValid_q <= frontValid_d;
            dmgSum_q     <= dmgSum_d;
        end
    end

    // The front slot may have died since it was registered; only feed it while alive.
    always_comb begin
        damageToEnemy = '0;
        if (frontValid_q && alive[frontIdx_q]) begin
            damageToEnemy[{frontIdx_q, 3'b000} +: 8] = playerDmgIn;
        end
    end

    assign canSpawn       = canSpawn_q;
    assign moveSCEN       = tickPulse_q;
    assign damageSCEN     = tickPulse_q;
    assign enemyFront     = frontPos_q;
    assign damageToPlayer = dmgSum_q;
    assign waveDone       = (state_q == DONE);
    assign busy           = active;

endmodule

// File: tb/tb_enemy_wave_controller.sv
// Directed bench for enemy_wave_controller with a simple enemy-slot model that
// comes alive on a spawn grant and dies on a bench kill request.
module tb_enemy_wave_controller;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  enemyDead;
    logic [35:0] enemyPos;
    logic [31:0] enemyDmg;
    logic [7:0]  playerDmgIn;
    logic [3:0]  canSpawn;
    logic        moveSCEN;
    logic        damageSCEN;
    logic [31:0] damageToEnemy;
    logic [8:0]  enemyFront;
    logic [9:0]  damageToPlayer;
    logic        waveDone;
    logic        busy;

    logic [3:0]  deadM;
    logic        loadEn;
    logic [3:0]  loadVal;
    logic [3:0]  killReq;

    int checks;
    int passes;

    typedef struct {
        logic [3:0]  dead;
        logic [35:0] pos;
        logic [31:0] dmg;
        logic [7:0]  pd;
        logic [8:0]  expFront;
        logic [31:0] expDte;
        logic [9:0]  expDtp;
    } vec_t;

    vec_t vecs[6];

    enemy_wave_controller #(
        .TICK_DIV (4),
        .SPAWN_GAP(2),
        .WAVE_SIZE(3)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .enemyDead     (enemyDead),
        .enemyPos      (enemyPos),
        .enemyDmg      (enemyDmg),
        .playerDmgIn   (playerDmgIn),
        .canSpawn      (canSpawn),
        .moveSCEN      (moveSCEN),
        .damageSCEN    (damageSCEN),
        .damageToEnemy (damageToEnemy),
        .enemyFront    (enemyFront),
        .damageToPlayer(damageToPlayer),
        .waveDone      (waveDone),
        .busy          (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Enemy slots: come alive the edge after a grant, die on a kill request.
    always @(posedge clk) begin
        if (loadEn) deadM <= loadVal;
        else        deadM <= (deadM | killReq) & ~canSpawn;
    end
    assign enemyDead = deadM;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic applyStimulus(input vec_t v);
        loadEn      = 1'b1;
        loadVal     = v.dead;
        enemyPos    = v.pos;
        enemyDmg    = v.dmg;
        playerDmgIn = v.pd;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " canSpawn"}, 32'(canSpawn), 32'h0);
        checkOutput({tag, " moveSCEN"}, 32'(moveSCEN), 32'h0);
        checkOutput({tag, " damageSCEN"}, 32'(damageSCEN), 32'h0);
        checkOutput({tag, " damageToEnemy"}, damageToEnemy, 32'h0);
        checkOutput({tag, " enemyFront"}, 32'(enemyFront), 32'h0);
        checkOutput({tag, " damageToPlayer"}, 32'(damageToPlayer), 32'h0);
        checkOutput({tag, " waveDone"}, 32'(waveDone), 32'h0);
        checkOutput({tag, " busy"}, 32'(busy), 32'h0);
    endtask

    initial begin
        int pulses;
        logic sawGrant;
        logic sawBusy;

        checks      = 0;
        passes      = 0;
        reset       = 1'b1;
        start       = 1'b0;
        loadEn      = 1'b1;
        loadVal     = 4'hF;
        killReq     = 4'h0;
        enemyPos    = '0;
        enemyDmg    = '0;
        playerDmgIn = '0;

        vecs[0] = '{4'b1000, {9'd99, 9'd30, 9'd30, 9'd10}, {8'd50, 8'd0, 8'd32, 8'd32}, 8'd5,
                    9'd30, 32'h0000_0500, 10'd64};
        vecs[1] = '{4'b1111, {9'd99, 9'd30, 9'd30, 9'd10}, {8'd50, 8'd0, 8'd32, 8'd32}, 8'd5,
                    9'd0, 32'h0, 10'd0};
        vecs[2] = '{4'b0000, {4{9'd511}}, {4{8'd255}}, 8'd7,
                    9'd511, 32'h0000_0007, 10'd1020};
        vecs[3] = '{4'b0111, {9'd200, 9'd400, 9'd300, 9'd100}, {8'd9, 8'd100, 8'd100, 8'd100}, 8'hAB,
                    9'd200, 32'hAB00_0000, 10'd9};
        vecs[4] = '{4'b0000, {9'd299, 9'd300, 9'd100, 9'd5}, {8'd4, 8'd3, 8'd2, 8'd1}, 8'h11,
                    9'd300, 32'h0011_0000, 10'd10};
        vecs[5] = '{4'b1010, {9'd0, 9'd50, 9'd400, 9'd50}, {8'd0, 8'd20, 8'd200, 8'd10}, 8'd3,
                    9'd50, 32'h0000_0003, 10'd30};

        tick(2);
        checkAllZero("reset");
        reset = 1'b0;

        for (int k = 0; k < 6; k++) begin
            applyStimulus(vecs[k]);
            tick(2);
            checkOutput($sformatf("vec%0d enemyFront", k), 32'(enemyFront), 32'(vecs[k].expFront));
            checkOutput($sformatf("vec%0d damageToEnemy", k), damageToEnemy, vecs[k].expDte);
            checkOutput($sformatf("vec%0d damageToPlayer", k), 32'(damageToPlayer), 32'(vecs[k].expDtp));
        end

        // Wave with all slots free: tick pacing, spawn spacing, then CLEAR.
        loadVal = 4'hF;
        loadEn  = 1'b1;
        tick(1);
        loadEn = 1'b0;
        start  = 1'b1;
        tick(1);
        start = 1'b0;
        checkOutput("busy after start", 32'(busy), 32'h1);
        checkOutput("no early tick", 32'(moveSCEN), 32'h0);
        tick(3);
        checkOutput("tick before pulse", 32'(moveSCEN), 32'h0);
        tick(1);
        checkOutput("first moveSCEN", 32'(moveSCEN), 32'h1);
        checkOutput("first damageSCEN", 32'(damageSCEN), 32'h1);
        checkOutput("first grant", 32'(canSpawn), 32'h1);
        tick(1);
        checkOutput("moveSCEN one cycle", 32'(moveSCEN), 32'h0);
        checkOutput("grant one cycle", 32'(canSpawn), 32'h0);
        tick(3);
        checkOutput("second tick pulse", 32'(moveSCEN), 32'h1);
        checkOutput("gap tick no grant", 32'(canSpawn), 32'h0);
        tick(4);
        checkOutput("second grant", 32'(canSpawn), 32'h2);
        tick(8);
        checkOutput("third grant", 32'(canSpawn), 32'h4);
        tick(1);
        checkOutput("clear busy", 32'(busy), 32'h1);
        checkOutput("clear not done", 32'(waveDone), 32'h0);
        pulses   = 0;
        sawGrant = 1'b0;
        for (int c = 0; c < 16; c++) begin
            tick(1);
            if (canSpawn != 4'd0) sawGrant = 1'b1;
            if (moveSCEN) pulses++;
        end
        checkOutput("no grant in clear", 32'(sawGrant), 32'h0);
        checkOutput("clear tick count", 32'(pulses), 32'd4);

        killReq = 4'b0111;
        tick(1);
        killReq = 4'h0;
        checkOutput("done not yet", 32'(waveDone), 32'h0);
        tick(1);
        checkOutput("waveDone", 32'(waveDone), 32'h1);
        checkOutput("done not busy", 32'(busy), 32'h0);

        start = 1'b1;
        tick(1);
        start = 1'b0;
        checkOutput("restart clears done", 32'(waveDone), 32'h0);
        checkOutput("restart busy", 32'(busy), 32'h1);
        tick(4);
        checkOutput("restart grant", 32'(canSpawn), 32'h1);

        // Asynchronous reset while a grant is outstanding.
        #1 reset = 1'b1;
        #1 checkAllZero("async reset");
        tick(1);
        reset    = 1'b0;
        sawGrant = 1'b0;
        sawBusy  = 1'b0;
        for (int c = 0; c < 12; c++) begin
            tick(1);
            if (canSpawn != 4'd0) sawGrant = 1'b1;
            if (busy) sawBusy = 1'b1;
        end
        checkOutput("idle after reset no grant", 32'(sawGrant), 32'h0);
        checkOutput("idle after reset not busy", 32'(sawBusy), 32'h0);

        // All slots occupied: retries until slot 2 dies; a start mid-wave is ignored.
        loadVal = 4'h0;
        loadEn  = 1'b1;
        tick(1);
        loadEn = 1'b0;
        start  = 1'b1;
        tick(1);
        start = 1'b0;
        tick(4);
        checkOutput("full tick1 pulse", 32'(moveSCEN), 32'h1);
        checkOutput("full tick1 no grant", 32'(canSpawn), 32'h0);
        tick(1);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(2);
        checkOutput("start ignored tick", 32'(moveSCEN), 32'h1);
        checkOutput("full tick2 no grant", 32'(canSpawn), 32'h0);
        killReq = 4'b0100;
        tick(1);
        killReq = 4'h0;
        tick(3);
        checkOutput("freed slot grant", 32'(canSpawn), 32'h4);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
